// File: rtl/spi_flash_target_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI flash responder.
// The DUMMY state exists only when SPI_FLASH_TARGET_FAST_READ_EN is defined.
package spi_flash_target_pkg;

    localparam logic [7:0] CmdWren     = 8'h06;
    localparam logic [7:0] CmdWrdi     = 8'h04;
    localparam logic [7:0] CmdRdsr     = 8'h05;
    localparam logic [7:0] CmdRdid     = 8'h9F;
    localparam logic [7:0] CmdRead     = 8'h03;
    localparam logic [7:0] CmdPp       = 8'h02;
    localparam logic [7:0] CmdFastRead = 8'h0B;

    localparam int unsigned StatusWipBit = 0;
    localparam int unsigned StatusWelBit = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
        DUMMY,
`endif
        DATA_OUT,
        DATA_IN,
        IGNORE
    } state_e;

    // Nothing is ever busy here, so WIP always reads back 0.
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s               = 8'h00;
        s[StatusWelBit] = wel;
        s[StatusWipBit] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/spi_target_sync_edge.sv
// Brings the asynchronous SPI pins into clk_i and derives sck edges and the
// cs deassert pulse from a third register stage.
module spi_target_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic cs_ni,
    input  logic copi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_n_o,
    output logic cs_deassert_o,
    output logic copi_o
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] copi_q;

    // cs resets to the deasserted level so a reset never looks like a frame start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            copi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            cs_q   <= {cs_q[1:0], cs_ni};
            copi_q <= {copi_q[0], copi_i};
        end
    end

    assign sck_rise_o    = sck_q[1] & ~sck_q[2];
    assign sck_fall_o    = ~sck_q[1] & sck_q[2];
    assign cs_n_o        = cs_q[1];
    assign cs_deassert_o = cs_q[1] & ~cs_q[2];
    assign copi_o        = copi_q[1];

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash responder serving WREN/WRDI/RDSR/RDID/READ/PP from an internal
// byte array. Define SPI_FLASH_TARGET_FAST_READ_EN to add FAST READ (0x0B).
module spi_flash_target #(
    parameter int unsigned AddrWidth = 12,
    parameter logic [23:0] JedecId   = 24'hEF4016,
    parameter int unsigned PageBytes = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic cs_ni,
    input  logic copi_i,
    output logic cipo_o,
    output logic wel_o,
    output logic active_o
);
    import spi_flash_target_pkg::*;

    localparam int unsigned          MemBytes = 2 ** AddrWidth;
    localparam logic [AddrWidth-1:0] PageMask = AddrWidth'(PageBytes - 1);

    logic sck_rise, sck_fall, cs_n, cs_deassert, copi;

    state_e               state_q, state_d;
    logic [2:0]           bit_q, bit_d;
    logic [6:0]           rx_q, rx_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           op_q, op_d;
    logic [1:0]           addr_byte_q, addr_byte_d;
    logic [1:0]           id_idx_q, id_idx_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 wel_q, wel_d;
    logic                 wrote_q, wrote_d;

    logic                 rise_ok, fall_ok, byte_done, mem_we;
    logic [7:0]           rx_byte;
    logic [AddrWidth+7:0] addr_shift;
    logic [AddrWidth-1:0] addr_asm;
    logic [7:0]           mem_q [MemBytes];

    spi_target_sync_edge u_sync (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sck_i        (sck_i),
        .cs_ni        (cs_ni),
        .copi_i       (copi_i),
        .sck_rise_o   (sck_rise),
        .sck_fall_o   (sck_fall),
        .cs_n_o       (cs_n),
        .cs_deassert_o(cs_deassert),
        .copi_o       (copi)
    );

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JedecId[23:16];
            2'd1:    return JedecId[15:8];
            2'd2:    return JedecId[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Edges seen while cs is high are dropped, so a byte that completes in the
    // same cycle cs is seen deasserted is discarded.
    assign rise_ok    = sck_rise & ~cs_n;
    assign fall_ok    = sck_fall & ~cs_n;
    assign byte_done  = rise_ok & (bit_q == 3'd7);
    assign rx_byte    = {rx_q, copi};
    assign addr_shift = {addr_q, rx_byte};
    assign addr_asm   = addr_shift[AddrWidth-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CmdRdsr, CmdRdid: state_d = DATA_OUT;
                            CmdRead:          state_d = ADDR;
                            CmdPp:            state_d = wel_q ? ADDR : IGNORE;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                            CmdFastRead:      state_d = ADDR;
`endif
                            default:          state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_done && addr_byte_q == 2'd2) begin
                        if (op_q == CmdPp) begin
                            state_d = DATA_IN;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                        end else if (op_q == CmdFastRead) begin
                            state_d = DUMMY;
`endif
                        end else begin
                            state_d = DATA_OUT;
                        end
                    end
                end
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                DUMMY: begin
                    if (byte_done) begin
                        state_d = DATA_OUT;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        active_o = 1'b0;
        cipo_o   = 1'b0;
        case (state_q)
            ADDR, DATA_IN: active_o = 1'b1;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
            DUMMY:         active_o = 1'b1;
`endif
            DATA_OUT: begin
                active_o = 1'b1;
                cipo_o   = tx_q[7];
            end
            default: ;
        endcase
    end

    always_comb begin
        bit_d       = bit_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        op_d        = op_q;
        addr_byte_d = addr_byte_q;
        id_idx_d    = id_idx_q;
        addr_d      = addr_q;
        wel_d       = wel_q;
        wrote_d     = wrote_q;
        mem_we      = 1'b0;

        if (cs_n) begin
            bit_d       = 3'd0;
            rx_d        = 7'd0;
            addr_byte_d = 2'd0;
            wrote_d     = 1'b0;
            if (cs_deassert && wrote_q) begin
                wel_d = 1'b0;
            end
        end else begin
            if (rise_ok) begin
                bit_d = bit_q + 3'd1;
                rx_d  = rx_byte[6:0];
            end
            // A freshly loaded byte must survive the fall that follows its load rise.
            if (fall_ok && state_q == DATA_OUT && bit_q != 3'd0) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        op_d        = rx_byte;
                        id_idx_d    = 2'd1;
                        addr_byte_d = 2'd0;
                        case (rx_byte)
                            CmdWren: wel_d = 1'b1;
                            CmdWrdi: wel_d = 1'b0;
                            CmdRdsr: tx_d  = status_byte(wel_q);
                            CmdRdid: tx_d  = id_byte(2'd0);
                            default: ;
                        endcase
                    end
                    ADDR: begin
                        addr_d = addr_asm;
                        if (addr_byte_q == 2'd2) begin
                            addr_byte_d = 2'd0;
                            if (op_q == CmdRead) begin
                                tx_d   = mem_q[addr_asm];
                                addr_d = addr_asm + 1'b1;
                            end
                        end else begin
                            addr_byte_d = addr_byte_q + 2'd1;
                        end
                    end
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
                    DUMMY: begin
                        tx_d   = mem_q[addr_q];
                        addr_d = addr_q + 1'b1;
                    end
`endif
                    DATA_OUT: begin
                        case (op_q)
                            CmdRdsr: tx_d = status_byte(wel_q);
                            CmdRdid: begin
                                tx_d = id_byte(id_idx_q);
                                if (id_idx_q != 2'd3) begin
                                    id_idx_d = id_idx_q + 2'd1;
                                end
                            end
                            default: begin
                                tx_d   = mem_q[addr_q];
                                addr_d = addr_q + 1'b1;
                            end
                        endcase
                    end
                    DATA_IN: begin
                        mem_we  = 1'b1;
                        wrote_d = 1'b1;
                        addr_d  = (addr_q & ~PageMask) | ((addr_q + 1'b1) & PageMask);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_q       <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            op_q        <= 8'h00;
            addr_byte_q <= 2'd0;
            id_idx_q    <= 2'd0;
            addr_q      <= '0;
            wel_q       <= 1'b0;
            wrote_q     <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            op_q        <= op_d;
            addr_byte_q <= addr_byte_d;
            id_idx_q    <= id_idx_d;
            addr_q      <= addr_d;
            wel_q       <= wel_d;
            wrote_q     <= wrote_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[addr_q] <= rx_byte;
        end
    end

    assign wel_o = wel_q;

endmodule
